hit_event_source: RTL and testbench
===================================

# hit_event_source

Transmitting end of the score path: runs a timed whack-a-target round, debounces player buttons and drives `hit` and `enA` into the scoring counter/seven-segment block. One target LED is lit per sample window. `hit` is asserted for a whole window when the lit target's button is pressed, so the scorer, sampling once per window, adds exactly one point per correct press.

## Interface
- SAMPLE_PERIOD, 20000002: window length in clock cycles; must equal the scorer's sampling period.
- DEBOUNCE_CYCLES, 500000: cycles a synchronized button level must stay stable before it is accepted.
- NUM_TARGETS, 4: number of targets/buttons; power of two, 2..8.
- ROUND_WINDOWS, 30: scored windows per round; 1..255.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  round start request; rising edge detected internally.
- buttons  in  NUM_TARGETS  raw asynchronous player buttons, active-high.
- target_leds  out  NUM_TARGETS  lit target: one-hot in PLAY, all-ones in DONE, zero otherwise.
- hit  out  1  to scorer `in`; high for the window in which a correct press occurred.
- enA  out  1  to scorer `enA`; high only in PLAY.
- window_tick  out  1  one-cycle pulse on the last cycle of each window.
- round_active  out  1  high in ARM and PLAY.
- windows_left  out  8  scored windows remaining, including the current window.

## Operation
- Buttons: each button passes through a 2-FF synchronizer, then a per-button debounce counter. A debounced 0->1 transition produces a one-cycle press. Held buttons never re-trigger.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle.
- Candidate target index is the LFSR low log2(NUM_TARGETS) bits. If it equals the previous target, index+1 (mod NUM_TARGETS) is used instead.
- The window counter runs 0..SAMPLE_PERIOD-1 in ARM and PLAY. window_tick is high when the counter equals SAMPLE_PERIOD-1. The counter wraps to 0.
- FSM states:
  - IDLE: outputs low. start rising edge -> ARM, counter cleared.
  - ARM: one lead-in window with LEDs off and enA low. At tick -> PLAY, first target chosen, windows_left=ROUND_WINDOWS.
  - PLAY: enA=1, one target lit.
    - The first press of the window decides the window. The lit button alone sets the hit latch. Any other button, including the lit button together with another button on the same cycle, sets the miss latch.
    - Once either latch is set, further presses in the window are ignored.
    - At tick: latches clear. windows_left decrements. If windows_left was 1 -> DONE; else a new target is chosen.
  - DONE: LEDs all on, enA low, hit low. start rising edge -> ARM.
- start edges in ARM/PLAY are ignored. start high at reset release is not an edge.
- hit = hit latch, registered. It is never high outside PLAY.

## Timing
- Reset (asynchronous, reset=0): FSM=IDLE, all outputs 0, counters and latches 0, debounced levels 0, LFSR=16'hACE1. This applies at any time, including mid-round.
- Button-to-press latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1.
- Press-to-hit latency: hit rises 1 cycle after the press cycle. It stays high through the tick cycle and falls on the cycle after the tick.
- A press on the tick cycle itself is dropped. It belongs to neither window.
- New target_leds value appears on the cycle after the tick, together with the decremented windows_left.
- enA rises the cycle after the ARM tick. It falls the cycle after the final PLAY tick.
- start edge to ARM: 1 cycle after the synchronized edge. The start input is synchronized with 2 FFs.

## Test plan
Use SAMPLE_PERIOD=16, DEBOUNCE_CYCLES=4, ROUND_WINDOWS=3, NUM_TARGETS=4 unless noted.
- Reset values: hold reset=0 for 5 cycles with buttons and start toggling -> every output stays 0. After release, target_leds=0 and round_active=0.
- Full round with correct presses: start pulse, then press the lit button mid-window in each of 3 windows -> hit high for the rest of each window, enA high for exactly 48 cycles, then DONE with target_leds=4'b1111 and windows_left=0.
- Wrong press and lockout: press a non-lit button, then the lit button in the same window -> hit stays 0. The next window is unaffected.
- Debounce: a 3-cycle glitch on the lit button -> no hit. A bounce pattern 1,0,1 followed by a 6-cycle hold -> exactly one press.
- Tick boundary: press detected exactly on the window_tick cycle -> hit 0 in both windows. A held button across the boundary produces no press in the new window.
- Reset mid-round: assert reset during window 2 with hit=1 -> all outputs 0 immediately. The next start runs a full 3-window round.

Source files
------------

// File: rtl/hit_event_source.sv
// hit_event_source: timed whack-a-target round generator.
// It lights one target per sample window, debounces the player buttons and
// drives hit/enA into the scorer. The scorer samples once per window, so a
// correct press must hold hit high for the rest of that window.
module hit_event_source #(
  parameter int SAMPLE_PERIOD   = 20000002,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_TARGETS     = 4,
  parameter int ROUND_WINDOWS   = 30
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [NUM_TARGETS-1:0] i_buttons,
  output logic [NUM_TARGETS-1:0] o_target_leds,
  output logic                   o_hit,
  output logic                   o_enA,
  output logic                   o_window_tick,
  output logic                   o_round_active,
  output logic [7:0]             o_windows_left
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       WIN_INIT = 8'(ROUND_WINDOWS);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // start synchronizer and edge detector
  logic r_start_s1;
  logic r_start_s2;
  logic r_start_d;
  logic w_start_rise;

  // button synchronizers, debounced levels and press pulses
  logic [NUM_TARGETS-1:0] r_btn_s1;
  logic [NUM_TARGETS-1:0] r_btn_s2;
  logic [NUM_TARGETS-1:0] w_db_level;
  logic [NUM_TARGETS-1:0] r_db_prev;
  logic [NUM_TARGETS-1:0] r_press;

  // round control
  logic [15:0]            r_lfsr;
  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [CNT_W-1:0]       r_win_cnt;
  logic                   w_active;
  logic                   w_tick;
  logic                   w_last_window;
  logic [IDX_W-1:0]       r_target_idx;
  logic [IDX_W-1:0]       w_cand_idx;
  logic [IDX_W-1:0]       w_next_idx;
  logic [NUM_TARGETS-1:0] w_lit_mask;
  logic [7:0]             r_windows_left;
  logic                   r_hit;
  logic                   r_miss;

  // Start synchronizer. These flops come out of reset high so that a start
  // input already held high at reset release never looks like a rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_s1 <= 1'b1;
      r_start_s2 <= 1'b1;
      r_start_d  <= 1'b1;
    end else begin
      r_start_s1 <= i_start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
    end
  end

  assign w_start_rise = r_start_s2 & ~r_start_d;

  // Button 2-FF synchronizers plus the press pulse generator (0->1 of the
  // debounced level, registered one cycle after the level is accepted).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn_s1  <= '0;
      r_btn_s2  <= '0;
      r_db_prev <= '0;
      r_press   <= '0;
    end else begin
      r_btn_s1  <= i_buttons;
      r_btn_s2  <= r_btn_s1;
      r_db_prev <= w_db_level;
      r_press   <= w_db_level & ~r_db_prev;
    end
  end

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_debounce
    logic            r_level;
    logic [DB_W-1:0] r_cnt;

    // Accept a new level only after it has differed from the current one for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else if (r_btn_s2[g] != r_level) begin
        if (r_cnt == DB_LAST) begin
          r_level <= r_btn_s2[g];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_db_level[g] = r_level;
  end

  // Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_active      = (r_state == S_ARM) || (r_state == S_PLAY);
  assign w_tick        = w_active && (r_win_cnt == CNT_LAST);
  assign w_last_window = (r_windows_left == 8'd1);

  // Next target: LFSR low bits, bumped by one when it would repeat.
  always_comb begin
    w_cand_idx = r_lfsr[IDX_W-1:0];
    w_next_idx = w_cand_idx;
    if (w_cand_idx == r_target_idx) begin
      w_next_idx = w_cand_idx + IDX_W'(1);
    end
  end

  assign w_lit_mask = NUM_TARGETS'(1) << r_target_idx;

  // Round state transitions.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_rise) w_state_next = S_ARM;
      S_ARM:   if (w_tick) w_state_next = S_PLAY;
      S_PLAY:  if (w_tick && w_last_window) w_state_next = S_DONE;
      S_DONE:  if (w_start_rise) w_state_next = S_ARM;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register and window counter; the counter only runs in ARM/PLAY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_win_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (!w_active || w_tick) begin
        r_win_cnt <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + CNT_W'(1);
      end
    end
  end

  // Target selection and windows-remaining bookkeeping at window ticks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target_idx   <= '0;
      r_windows_left <= '0;
    end else if (w_tick) begin
      if (r_state == S_ARM) begin
        r_target_idx   <= w_next_idx;
        r_windows_left <= WIN_INIT;
      end else begin
        r_windows_left <= r_windows_left - 8'd1;
        if (!w_last_window) begin
          r_target_idx <= w_next_idx;
        end
      end
    end
  end

  // Hit/miss latches: the first press of a window decides it. Clearing on
  // the tick takes priority, so a press on the tick cycle is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else if ((r_state != S_PLAY) || w_tick) begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else if (!r_hit && !r_miss && (|r_press)) begin
      if (r_press == w_lit_mask) begin
        r_hit <= 1'b1;
      end else begin
        r_miss <= 1'b1;
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    o_target_leds = '0;
    if (r_state == S_PLAY) begin
      o_target_leds = w_lit_mask;
    end else if (r_state == S_DONE) begin
      o_target_leds = '1;
    end
    o_hit          = r_hit;
    o_enA          = (r_state == S_PLAY);
    o_window_tick  = w_tick;
    o_round_active = w_active;
    o_windows_left = r_windows_left;
  end

endmodule

// File: tb/tb_hit_event_source.sv
// Directed bench for hit_event_source with short windows (16 cycles),
// 4-cycle debounce, 3-window rounds and 4 targets.
module tb_hit_event_source;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] buttons;
  logic [3:0] leds;
  logic       hit;
  logic       ena;
  logic       tick;
  logic       active;
  logic [7:0] wleft;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  int          m_tgt = 0;

  always #5 clk = ~clk;

  hit_event_source #(
    .SAMPLE_PERIOD(16),
    .DEBOUNCE_CYCLES(4),
    .NUM_TARGETS(4),
    .ROUND_WINDOWS(3)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_buttons(buttons),
    .o_target_leds(leds),
    .o_hit(hit),
    .o_enA(ena),
    .o_window_tick(tick),
    .o_round_active(active),
    .o_windows_left(wleft)
  );

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] lfsr_ahead(input logic [15:0] v, input int n);
    logic [15:0] t = v;
    for (int k = 0; k < n; k++) t = lfsr_adv(t);
    return t;
  endfunction

  function automatic int choose(input logic [15:0] v, input int prev);
    int c = int'(v[1:0]);
    if (c == prev) c = (c + 1) % 4;
    return c;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] one = 4'b0001;
    return one << i;
  endfunction

  // Reference LFSR, reseeded by the same reset as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_adv(m_lfsr);
  end

  // Move to the next sampling point; on a non-final tick pick the next target.
  task automatic next_cycle(input int w, input int c);
    if (c == 15 && w < 2) m_tgt = choose(m_lfsr, m_tgt);
    @(negedge clk);
  endtask

  // Pulse start and walk through ARM; returns on PLAY window 0, cycle 0.
  task automatic start_round;
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    m_tgt = choose(m_lfsr, m_tgt);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    start   = 1'b0;
    buttons = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start   = i[0];
      buttons = 4'(i * 5 + 3);
      #1;
      n_checks++;
      if ({leds, hit, ena, tick, active, wleft} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h, expected 0000", i,
                 {leds, hit, ena, tick, active, wleft});
      end
    end
    @(negedge clk);
    start   = 1'b0;
    buttons = 4'h0;
    rst_n   = 1'b1;
    m_tgt   = 0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (leds !== 4'h0) begin
      n_fail++; $display("FAIL post_reset_leds: got %h, expected 0", leds);
    end
    n_checks++;
    if ({active, ena, hit, wleft} !== 11'h0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h, expected 000", {active, ena, hit, wleft});
    end
  endtask

  task automatic test_full_round;
    int en_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++; $display("FAIL idle_active: got %b, expected 0", active);
    end
    repeat (3) @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({active, ena, leds} !== 6'b10_0000) begin
      n_fail++; $display("FAIL arm_state: got %b, expected 100000", {active, ena, leds});
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ena === 1'b1) en_cnt++;
    end
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++; $display("FAIL arm_tick: got %b, expected 1", tick);
    end
    m_tgt = choose(m_lfsr, m_tgt);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 16; c++) begin
        if (ena === 1'b1) en_cnt++;
        if (c == 2) buttons = onehot(m_tgt);
        if (c == 8) buttons = 4'h0;
        if (c == 0) begin
          n_checks++;
          if (leds !== onehot(m_tgt)) begin
            n_fail++; $display("FAIL round_leds[w%0d]: got %b, expected %b", w, leds, onehot(m_tgt));
          end
          n_checks++;
          if (wleft !== 8'(3 - w)) begin
            n_fail++; $display("FAIL round_wleft[w%0d]: got %0d, expected %0d", w, wleft, 3 - w);
          end
        end
        if (c == 9) begin
          n_checks++;
          if (hit !== 1'b0) begin
            n_fail++; $display("FAIL hit_early[w%0d]: got %b, expected 0", w, hit);
          end
        end
        if (c == 10) begin
          n_checks++;
          if (hit !== 1'b1) begin
            n_fail++; $display("FAIL hit_rise[w%0d]: got %b, expected 1", w, hit);
          end
        end
        if (c == 15) begin
          n_checks++;
          if ({hit, tick} !== 2'b11) begin
            n_fail++; $display("FAIL hit_at_tick[w%0d]: got %b, expected 11", w, {hit, tick});
          end
        end
        next_cycle(w, c);
      end
    end
    n_checks++;
    if ({leds, wleft} !== 12'hF00) begin
      n_fail++; $display("FAIL done_leds_wleft: got %h, expected f00", {leds, wleft});
    end
    n_checks++;
    if ({hit, ena, active} !== 3'b000) begin
      n_fail++; $display("FAIL done_flags: got %b, expected 000", {hit, ena, active});
    end
    n_checks++;
    if (en_cnt !== 48) begin
      n_fail++; $display("FAIL ena_cycles: got %0d, expected 48", en_cnt);
    end
  endtask

  task automatic test_wrong_press;
    logic [2:0] seen = '0;
    start_round();
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 16; c++) begin
        if (w == 0) begin
          if (c == 1) buttons = onehot((m_tgt + 1) % 4);
          if (c == 3) buttons = onehot((m_tgt + 1) % 4) | onehot(m_tgt);
          if (c == 5) buttons = onehot(m_tgt);
          if (c == 9) buttons = 4'h0;
        end else if (w == 1) begin
          if (c == 2) buttons = onehot(m_tgt);
          if (c == 8) buttons = 4'h0;
          if (c == 12) begin
            n_checks++;
            if (hit !== 1'b1) begin
              n_fail++; $display("FAIL after_lockout_hit: got %b, expected 1", hit);
            end
          end
        end else begin
          if (c == 2) buttons = onehot(m_tgt) | onehot((m_tgt + 2) % 4);
          if (c == 8) buttons = 4'h0;
        end
        if (hit === 1'b1) seen[w] = 1'b1;
        next_cycle(w, c);
      end
    end
    n_checks++;
    if (seen[0] !== 1'b0) begin
      n_fail++; $display("FAIL wrong_then_lit: got hit %b, expected 0", seen[0]);
    end
    n_checks++;
    if (seen[2] !== 1'b0) begin
      n_fail++; $display("FAIL lit_plus_other: got hit %b, expected 0", seen[2]);
    end
  endtask

  task automatic test_debounce;
    logic [2:0] seen = '0;
    start_round();
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 16; c++) begin
        if (w == 0) begin
          if (c == 2) buttons = onehot(m_tgt);
          if (c == 5) buttons = 4'h0;
        end else if (w == 1) begin
          if (c == 1 || c == 3 || c == 5) buttons = onehot(m_tgt);
          if (c == 2 || c == 4 || c == 11) buttons = 4'h0;
          if (c == 12) begin
            n_checks++;
            if (hit !== 1'b0) begin
              n_fail++; $display("FAIL bounce_latency: got %b, expected 0", hit);
            end
          end
          if (c == 13 || c == 15) begin
            n_checks++;
            if (hit !== 1'b1) begin
              n_fail++; $display("FAIL bounce_hit[c%0d]: got %b, expected 1", c, hit);
            end
          end
        end
        if (hit === 1'b1) seen[w] = 1'b1;
        next_cycle(w, c);
      end
    end
    n_checks++;
    if (seen[0] !== 1'b0) begin
      n_fail++; $display("FAIL glitch_3cyc: got hit %b, expected 0", seen[0]);
    end
    n_checks++;
    if (seen[2] !== 1'b0) begin
      n_fail++; $display("FAIL after_bounce_window: got hit %b, expected 0", seen[2]);
    end
  endtask

  task automatic test_tick_boundary;
    logic [2:0] seen = '0;
    int t2 = 0;
    start_round();
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 16; c++) begin
        if (w == 0 && c == 8)  buttons = onehot(m_tgt);
        if (w == 0 && c == 12) buttons = 4'h0;
        if (w == 1 && c == 8) begin
          t2 = choose(lfsr_ahead(m_lfsr, 7), m_tgt);
          buttons = onehot(t2);
        end
        if (w == 2 && c == 0) begin
          n_checks++;
          if (leds !== onehot(t2)) begin
            n_fail++; $display("FAIL predicted_target: got %b, expected %b", leds, onehot(t2));
          end
        end
        if (hit === 1'b1) seen[w] = 1'b1;
        next_cycle(w, c);
      end
    end
    buttons = 4'h0;
    n_checks++;
    if (seen[0] !== 1'b0) begin
      n_fail++; $display("FAIL tick_press_old_window: got hit %b, expected 0", seen[0]);
    end
    n_checks++;
    if (seen[1] !== 1'b0) begin
      n_fail++; $display("FAIL tick_press_new_window: got hit %b, expected 0", seen[1]);
    end
    n_checks++;
    if (seen[2] !== 1'b0) begin
      n_fail++; $display("FAIL held_no_retrigger: got hit %b, expected 0", seen[2]);
    end
  endtask

  task automatic test_reset_mid_round;
    int en_cnt = 0;
    start_round();
    for (int c = 0; c < 16; c++) next_cycle(0, c);
    for (int c = 0; c < 12; c++) begin
      if (c == 2) buttons = onehot(m_tgt);
      if (c == 8) buttons = 4'h0;
      if (c < 11) @(negedge clk);
    end
    n_checks++;
    if (hit !== 1'b1) begin
      n_fail++; $display("FAIL mid_round_pre_hit: got %b, expected 1", hit);
    end
    rst_n = 1'b0;
    m_tgt = 0;
    #1;
    n_checks++;
    if ({leds, hit, ena, tick, active, wleft} !== 16'h0) begin
      n_fail++; $display("FAIL mid_round_reset: got %h, expected 0000",
                         {leds, hit, ena, tick, active, wleft});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    start_round();
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 16; c++) begin
        if (ena === 1'b1) en_cnt++;
        if (c == 2) buttons = onehot(m_tgt);
        if (c == 8) buttons = 4'h0;
        if (c == 0) begin
          n_checks++;
          if (leds !== onehot(m_tgt)) begin
            n_fail++; $display("FAIL rerun_leds[w%0d]: got %b, expected %b", w, leds, onehot(m_tgt));
          end
        end
        if (c == 11) begin
          n_checks++;
          if (hit !== 1'b1) begin
            n_fail++; $display("FAIL rerun_hit[w%0d]: got %b, expected 1", w, hit);
          end
        end
        next_cycle(w, c);
      end
    end
    n_checks++;
    if (en_cnt !== 48) begin
      n_fail++; $display("FAIL rerun_ena_cycles: got %0d, expected 48", en_cnt);
    end
    n_checks++;
    if ({leds, wleft, ena} !== 13'h1E00) begin
      n_fail++; $display("FAIL rerun_done: got %h, expected 1e00", {leds, wleft, ena});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_round();
    test_wrong_press();
    test_debounce();
    test_tick_boundary();
    test_reset_mid_round();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
